// File: rtl/hazard_stall_controller.sv
// Decode-stage sequencing controller: 3-slot writer scoreboard (EX/MEM/WB), multiply busy FSM, branch flush.
// Define FORWARDING_EN for bypass selects with load-use-only stalls; otherwise any in-flight writer stalls.
module hazard_stall_controller #(
  parameter int MUL_LATENCY = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ID_Valid,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic       ID_RegWrite,
  input  logic [4:0] ID_Rd,
  input  logic       ID_MemRead,
  input  logic       ID_IsMul,
  input  logic       BranchTaken,
  output logic       PCWrite,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Bubble,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB,
  output logic       Busy
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       load;
  } slot_t;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  localparam int              CNT_W     = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam bit              MUL_MULTI = (MUL_LATENCY > 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  slot_t            ex_q, mem_q, wb_q;
  slot_t            ex_nxt, mem_nxt, wb_nxt;
  logic             busy_st;
  logic             dep_ex, dep_mem, dep_wb;
  logic             haz, issue, mul_start;
  logic [1:0]       fwd_a, fwd_b;
  logic             unused_load;

  function automatic logic match(input slot_t s, input logic [4:0] r);
    return s.valid && (s.rd == r) && (r != 5'd0);
  endfunction

  function automatic logic depends(input slot_t s, input logic uses_rs, input logic uses_rt,
                                   input logic [4:0] rs, input logic [4:0] rt);
    return (uses_rs && match(s, rs)) || (uses_rt && match(s, rt));
  endfunction

  assign busy_st = (state == MUL_BUSY);

  assign dep_ex  = ID_Valid && depends(ex_q,  ID_UsesRs, ID_UsesRt, ID_Rs, ID_Rt);
  assign dep_mem = ID_Valid && depends(mem_q, ID_UsesRs, ID_UsesRt, ID_Rs, ID_Rt);
  assign dep_wb  = ID_Valid && depends(wb_q,  ID_UsesRs, ID_UsesRt, ID_Rs, ID_Rt);

`ifdef FORWARDING_EN
  // Youngest producer wins so the bypass always sees the most recent value.
  function automatic logic [1:0] pick(input slot_t ex, input slot_t mem, input slot_t wb,
                                      input logic [4:0] r);
    if (match(ex, r))       return 2'b01;
    else if (match(mem, r)) return 2'b10;
    else if (match(wb, r))  return 2'b11;
    else                    return 2'b00;
  endfunction

  assign haz   = dep_ex && ex_q.load;
  assign fwd_a = pick(ex_q, mem_q, wb_q, ID_Rs);
  assign fwd_b = pick(ex_q, mem_q, wb_q, ID_Rt);
`else
  assign haz   = dep_ex || dep_mem || dep_wb;
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  // WB load flag is carried for slot uniformity but nothing downstream consumes it.
  assign unused_load = wb_q.load;

  assign issue     = (state == RUN) && !haz && !BranchTaken && ID_Valid;
  assign mul_start = issue && ID_IsMul && MUL_MULTI;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (mul_start) begin
          state_nxt = MUL_BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      MUL_BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // While the multiply occupies EX, the EX slot holds its writer and MEM receives a bubble.
  always_comb begin
    wb_nxt  = mem_q;
    mem_nxt = busy_st ? slot_t'('0) : ex_q;
    if (busy_st) ex_nxt = ex_q;
    else         ex_nxt = {issue && ID_RegWrite && (ID_Rd != 5'd0), ID_Rd, ID_MemRead};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= '0;
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ex_q  <= ex_nxt;
      mem_q <= mem_nxt;
      wb_q  <= wb_nxt;
    end
  end

  // Output priority: reset, then branch flush, then multiply/hazard stall, then normal flow.
  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    ForwardA    = fwd_a;
    ForwardB    = fwd_b;
    if (Reset) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
      ForwardA    = 2'b00;
      ForwardB    = 2'b00;
    end else if (BranchTaken) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (busy_st || haz) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end
  end

  assign Busy = busy_st;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios with literal expectations plus random traffic
// checked every cycle against a queue-based pipeline model (follows FORWARDING_EN like the design).
module tb_hazard_stall_controller;

  localparam int MUL_LATENCY = 4;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       ID_Valid, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead, ID_IsMul, BranchTaken;
  logic [4:0] ID_Rs, ID_Rt, ID_Rd;
  logic       PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Busy;
  logic [1:0] ForwardA, ForwardB;

  always #5 Clock = ~Clock;

  hazard_stall_controller #(.MUL_LATENCY(MUL_LATENCY)) dut (
    .Clock(Clock), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_RegWrite(ID_RegWrite), .ID_Rd(ID_Rd),
    .ID_MemRead(ID_MemRead), .ID_IsMul(ID_IsMul), .BranchTaken(BranchTaken),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .ForwardA(ForwardA), .ForwardB(ForwardB), .Busy(Busy)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // inflight[0] is the youngest writer (EX), inflight[2] the oldest (WB).
  typedef struct {
    bit v;
    int rd;
    bit ld;
  } ent_t;

  ent_t inflight[$];
  ent_t e_empty;
  int   mul_left;

  function automatic bit hit(input ent_t e, input logic [4:0] r);
    return e.v && (e.rd == int'(r)) && (r != 5'd0);
  endfunction

  function automatic bit dep_at(input int k);
    return ID_Valid && ((ID_UsesRs && hit(inflight[k], ID_Rs)) ||
                        (ID_UsesRt && hit(inflight[k], ID_Rt)));
  endfunction

  function automatic bit model_haz();
`ifdef FORWARDING_EN
    return dep_at(0) && inflight[0].ld;
`else
    return dep_at(0) || dep_at(1) || dep_at(2);
`endif
  endfunction

  function automatic int model_fwd(input logic [4:0] r);
`ifdef FORWARDING_EN
    for (int k = 0; k < 3; k++) if (hit(inflight[k], r)) return k + 1;
`endif
    return (r === 5'bx) ? 0 : 0;
  endfunction

  task automatic model_reset();
    e_empty.v  = 1'b0;
    e_empty.rd = 0;
    e_empty.ld = 1'b0;
    inflight.delete();
    repeat (3) inflight.push_back(e_empty);
    mul_left = 0;
  endtask

  always @(posedge Clock or posedge Reset) begin
    bit   busy;
    bit   iss;
    ent_t ne;
    if (Reset) begin
      model_reset();
    end else begin
      busy  = (mul_left > 0);
      iss   = !busy && !model_haz() && !BranchTaken && ID_Valid;
      ne.v  = iss && ID_RegWrite && (ID_Rd != 5'd0);
      ne.rd = int'(ID_Rd);
      ne.ld = ID_MemRead;
      if (busy) begin
        inflight = {inflight[0], e_empty, inflight[1]};
        mul_left--;
      end else begin
        inflight.push_front(ne);
        void'(inflight.pop_back());
        if (iss && ID_IsMul) mul_left = MUL_LATENCY - 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Clock) begin
    int e_pc, e_ifw, e_fl, e_bub;
    if (cmp_en) begin
      if (Reset) begin
        chk("rst_pcwrite", int'(PCWrite), 0);
        chk("rst_ifid_write", int'(IFID_Write), 0);
        chk("rst_flush", int'(IFID_Flush), 0);
        chk("rst_bubble", int'(IDEX_Bubble), 1);
        chk("rst_fwd_a", int'(ForwardA), 0);
        chk("rst_fwd_b", int'(ForwardB), 0);
        chk("rst_busy", int'(Busy), 0);
      end else begin
        if (BranchTaken) begin
          e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 1;
        end else if ((mul_left > 0) || model_haz()) begin
          e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1;
        end else begin
          e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0;
        end
        chk("pcwrite", int'(PCWrite), e_pc);
        chk("ifid_write", int'(IFID_Write), e_ifw);
        chk("ifid_flush", int'(IFID_Flush), e_fl);
        chk("idex_bubble", int'(IDEX_Bubble), e_bub);
        chk("forward_a", int'(ForwardA), model_fwd(ID_Rs));
        chk("forward_b", int'(ForwardB), model_fwd(ID_Rt));
        chk("busy", int'(Busy), (mul_left > 0) ? 1 : 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit rw, input int rd, input bit mr, input bit mul, input bit br);
    ID_Valid    = v;
    ID_Rs       = 5'(rs);
    ID_Rt       = 5'(rt);
    ID_UsesRs   = urs;
    ID_UsesRt   = urt;
    ID_RegWrite = rw;
    ID_Rd       = 5'(rd);
    ID_MemRead  = mr;
    ID_IsMul    = mul;
    BranchTaken = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic nxt();
    @(posedge Clock);
    #1;
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1 Reset = 1'b1;
    cmp_en = 1'b1;
    @(negedge Clock);
    chk("lit_reset_pcwrite", int'(PCWrite), 0);
    chk("lit_reset_bubble", int'(IDEX_Bubble), 1);
    @(posedge Clock);
    #1 Reset = 1'b0;

    // load then dependent reader: one bubble with forwarding, MEM stall without
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    @(negedge Clock);
    chk("lit_lw_issue_pc", int'(PCWrite), 1);
    nxt();
    drive(1, 8, 10, 1, 1, 1, 9, 0, 0, 0);
    @(negedge Clock);
    chk("lit_loaduse_pc", int'(PCWrite), 0);
    chk("lit_loaduse_ifw", int'(IFID_Write), 0);
    chk("lit_loaduse_bubble", int'(IDEX_Bubble), 1);
    nxt();
    @(negedge Clock);
    chk("lit_after_lu_pc", int'(PCWrite), FWD ? 1 : 0);
    chk("lit_after_lu_fwda", int'(ForwardA), FWD ? 2 : 0);
    nxt();
    drain(4);

    // ALU writer then back-to-back reader of both operands
    drive(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    nxt();
    drive(1, 8, 8, 1, 1, 1, 11, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      chk("lit_alu_use_pc", int'(PCWrite), (FWD || i == 3) ? 1 : 0);
      if (i == 0) begin
        chk("lit_alu_use_fwda", int'(ForwardA), FWD ? 1 : 0);
        chk("lit_alu_use_fwdb", int'(ForwardB), FWD ? 1 : 0);
      end
      nxt();
    end
    drain(4);

    // $0 never hazards
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    nxt();
    drive(1, 0, 0, 1, 1, 1, 5, 0, 0, 0);
    @(negedge Clock);
    chk("lit_r0_pc", int'(PCWrite), 1);
    chk("lit_r0_fwda", int'(ForwardA), 0);
    chk("lit_r0_fwdb", int'(ForwardB), 0);
    nxt();
    drain(4);

    // multiply: MUL_LATENCY-1 busy cycles, then dependent reader
    drive(1, 0, 0, 0, 0, 1, 8, 0, 1, 0);
    @(negedge Clock);
    chk("lit_mul_issue_busy", int'(Busy), 0);
    nxt();
    idle();
    for (int i = 0; i < MUL_LATENCY - 1; i++) begin
      @(negedge Clock);
      chk("lit_mul_busy", int'(Busy), 1);
      chk("lit_mul_pc", int'(PCWrite), 0);
      nxt();
    end
    drive(1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge Clock);
    chk("lit_mul_done_busy", int'(Busy), 0);
    chk("lit_mul_dep_pc", int'(PCWrite), FWD ? 1 : 0);
    chk("lit_mul_dep_fwda", int'(ForwardA), FWD ? 1 : 0);
    nxt();
    drain(5);

    // branch during load-use stall
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    nxt();
    drive(1, 8, 0, 1, 0, 1, 9, 0, 0, 1);
    @(negedge Clock);
    chk("lit_br_flush", int'(IFID_Flush), 1);
    chk("lit_br_pc", int'(PCWrite), 1);
    chk("lit_br_ifw", int'(IFID_Write), 1);
    chk("lit_br_bubble", int'(IDEX_Bubble), 1);
    nxt();
    drain(4);

    // reset pulse in MUL_BUSY
    drive(1, 0, 0, 0, 0, 1, 8, 0, 1, 0);
    nxt();
    idle();
    @(negedge Clock);
    chk("lit_rstmul_busy_before", int'(Busy), 1);
    nxt();
    Reset = 1'b1;
    #1;
    chk("lit_rstmul_busy_now", int'(Busy), 0);
    chk("lit_rstmul_pc", int'(PCWrite), 0);
    chk("lit_rstmul_bubble", int'(IDEX_Bubble), 1);
    #1 Reset = 1'b0;
    drive(1, 8, 8, 1, 1, 0, 0, 0, 0, 0);
    @(negedge Clock);
    chk("lit_rstmul_after_busy", int'(Busy), 0);
    chk("lit_rstmul_after_pc", int'(PCWrite), 1);
    chk("lit_rstmul_after_fwda", int'(ForwardA), 0);
    nxt();

    // random traffic over a small register set so hazards are frequent
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        Reset = 1'b1;
        #1 Reset = 1'b0;
      end
      drive($urandom_range(0, 3) != 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0);
      nxt();
    end

    idle();
    @(negedge Clock);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
